// File: rtl/ahblite_sram_slave.sv
// ahblite_sram_slave
//   AHB-Lite responder in front of a single-port synchronous SRAM (TCM).
//   Reads and writes are zero-wait. Writes are posted through a one-entry
//   buffer that drains into idle SRAM cycles and is merged into read data.
//   Misaligned or oversized transfers get the two-cycle ERROR response.
//
// Ports
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL..HWDATA, HREADY  AHB-Lite address/data-phase inputs from the matrix
//   HREADYOUT, HRESP      slave ready and response (OKAY/ERROR)
//   HRDATA                read data, zero outside a read data phase
//   SRAM_CS/WEN/ADDR/WDATA  SRAM command port (WEN per byte, 0000 = read)
//   SRAM_RDATA            SRAM read data, valid the cycle after a CS read
module ahblite_sram_slave #(
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [31:0]           HRDATA,
    output logic                  SRAM_CS,
    output logic [3:0]            SRAM_WEN,
    output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
    output logic [31:0]           SRAM_WDATA,
    input  logic [31:0]           SRAM_RDATA
);

    localparam int unsigned AW         = ADDR_WIDTH;
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_e;

    state_e          state_q, state_d;

    logic            dp_valid_q;
    logic            dp_write_q;
    logic [AW-1:0]   dp_addr_q;
    logic [3:0]      dp_mask_q;

    logic            wb_valid_q;
    logic [AW-1:0]   wb_addr_q;
    logic [31:0]     wb_data_q;
    logic [3:0]      wb_mask_q;

    logic [AW-1:0]   haddr_word;
    logic [3:0]      xfer_mask;
    logic            xfer_err;
    logic            accept;
    logic            acc_ok;
    logic            acc_err;
    logic            rd_req;
    logic            drain;
    logic            stall;
    logic            wb_load;
    logic            rd_phase;
    logic            wb_hit;

    // Region decode lives in the matrix; high address bits and HTRANS[0] are don't-care.
    logic            unused_bits;
    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    assign haddr_word = HADDR[AW+1:2];

    // Byte lanes and alignment check for the address-phase transfer.
    always_comb begin
        xfer_mask = 4'b0000;
        xfer_err  = 1'b0;
        case (HSIZE)
            3'd0: xfer_mask = 4'b0001 << HADDR[1:0];
            3'd1: begin
                xfer_mask = HADDR[1] ? 4'b1100 : 4'b0011;
                xfer_err  = HADDR[0];
            end
            3'd2: begin
                xfer_mask = 4'b1111;
                xfer_err  = (HADDR[1:0] != 2'b00);
            end
            default: xfer_err = 1'b1;
        endcase
    end

    assign accept  = HSEL & HREADY & HTRANS[1];
    assign acc_ok  = accept & ~xfer_err;
    assign acc_err = accept & xfer_err;

    // SRAM port arbitration: an address-phase read wins, otherwise the buffer drains.
    // Both are suppressed in reset so a pending write is discarded, not committed.
    assign rd_req = acc_ok & ~HWRITE & ~HRESET;
    assign drain  = wb_valid_q & ~rd_req & ~HRESET;

    // A read request would steal the port from a full buffer while the current
    // write still needs a slot; hold the write for one cycle so the buffer drains.
    // Uses raw HSEL/HTRANS so HREADYOUT never depends on HREADY.
    assign stall = dp_valid_q & dp_write_q & wb_valid_q & HSEL & HTRANS[1] & ~HWRITE;

    assign wb_load = dp_valid_q & dp_write_q & HREADYOUT;

    // Error-response state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Error-response next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = RESP_OKAY;
        case (state_q)
            ST_IDLE: begin
                if (acc_err) begin
                    state_d = ST_ERR1;
                end
                HREADYOUT = ~stall;
            end
            ST_ERR1: begin
                state_d   = ST_ERR2;
                HREADYOUT = 1'b0;
                HRESP     = RESP_ERROR;
            end
            ST_ERR2: begin
                state_d = acc_err ? ST_ERR1 : ST_IDLE;
                HRESP   = RESP_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
        if (HRESET) begin
            HREADYOUT = 1'b1;
            HRESP     = RESP_OKAY;
        end
    end

    // Data-phase control captured at every completed address phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_mask_q  <= 4'b0000;
        end else if (HREADY) begin
            dp_valid_q <= acc_ok;
            dp_write_q <= HWRITE;
            dp_addr_q  <= haddr_word;
            dp_mask_q  <= xfer_mask;
        end
    end

    // Write buffer occupancy; a reload in the drain cycle keeps it full.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wb_valid_q <= 1'b0;
        end else if (wb_load) begin
            wb_valid_q <= 1'b1;
        end else if (drain) begin
            wb_valid_q <= 1'b0;
        end
    end

    // Write buffer payload.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wb_addr_q <= '0;
            wb_data_q <= 32'h0;
            wb_mask_q <= 4'b0000;
        end else if (wb_load) begin
            wb_addr_q <= dp_addr_q;
            wb_data_q <= HWDATA;
            wb_mask_q <= dp_mask_q;
        end
    end

    // SRAM command port.
    always_comb begin
        SRAM_CS    = rd_req | drain;
        SRAM_WEN   = drain ? wb_mask_q : 4'b0000;
        SRAM_ADDR  = rd_req ? haddr_word : wb_addr_q;
        SRAM_WDATA = wb_data_q;
    end

    // Read data: buffered bytes for the same word override the SRAM copy.
    assign rd_phase = dp_valid_q & ~dp_write_q & ~HRESET;
    assign wb_hit   = wb_valid_q & (wb_addr_q == dp_addr_q);

    always_comb begin
        HRDATA = 32'h0;
        if (rd_phase) begin
            for (int i = 0; i < 4; i++) begin
                HRDATA[8*i +: 8] = (wb_hit & wb_mask_q[i]) ? wb_data_q[8*i +: 8]
                                                           : SRAM_RDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// Testbench for ahblite_sram_slave: SRAM fixture, pipelined AHB master and a
// word-array reference memory updated in transfer-completion order.
module tb_ahblite_sram_slave;

    localparam int unsigned AW    = 13;
    localparam int          GUARD = 5000;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } item_t;

    typedef struct {
        int          cyc;
        logic [3:0]  wen;
        logic [12:0] addr;
        logic [31:0] data;
    } log_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic        sram_cs;
    logic [3:0]  sram_wen;
    logic [12:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic        pre_en;
    logic [12:0] pre_addr;
    logic [31:0] pre_data;

    logic [31:0] sram [0:(1<<AW)-1];
    logic [31:0] ref_mem [16];
    log_t        logq[$];
    item_t       seq[$];
    int          waits[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          stall_cyc = -1;
    int          log_base;
    logic [31:0] last_rdata;
    logic [31:0] old_val;

    always #5 hclk = ~hclk;

    // Single-slave matrix: global ready is this slave's ready.
    assign hready = hreadyout;

    ahblite_sram_slave #(.ADDR_WIDTH(AW)) dut (
        .HCLK       (hclk),
        .HRESET     (hreset),
        .HSEL       (hsel),
        .HADDR      (haddr),
        .HTRANS     (htrans),
        .HSIZE      (hsize),
        .HWRITE     (hwrite),
        .HWDATA     (hwdata),
        .HREADY     (hready),
        .HREADYOUT  (hreadyout),
        .HRESP      (hresp),
        .HRDATA     (hrdata),
        .SRAM_CS    (sram_cs),
        .SRAM_WEN   (sram_wen),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WDATA (sram_wdata),
        .SRAM_RDATA (sram_rdata)
    );

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] nw,
                                                input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // SRAM fixture with an access log.
    always @(posedge hclk) begin
        if (pre_en) begin
            sram[pre_addr] <= pre_data;
        end else if (sram_cs) begin
            logq.push_back('{cyc: cyc, wen: sram_wen, addr: sram_addr, data: sram_wdata});
            if (sram_wen == 4'b0000) sram_rdata <= sram[sram_addr];
            else sram[sram_addr] <= merge_bytes(sram[sram_addr], sram_wdata, sram_wen);
        end
        cyc <= cyc + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Transfer is an error if oversized or not naturally aligned to its size.
    function automatic bit is_err(input logic [2:0] sz, input logic [31:0] a);
        if (sz > 3'd2) return 1'b1;
        return (int'(a[1:0]) % (1 << sz)) != 0;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
        int nb;
        int lo;
        int w;
        nb = 1 << sz;
        lo = int'(a[1:0]);
        w  = int'(a[5:2]);
        for (int b = lo; b < lo + nb; b++) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic add_xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                            input logic [31:0] d);
        seq.push_back('{sel: 1'b1, trans: 2'b10, wr: wr, addr: a, size: sz, wdata: d});
    endtask

    task automatic add_idle();
        seq.push_back('{sel: 1'b0, trans: 2'b00, wr: 1'b0, addr: 32'h0, size: 3'd0, wdata: 32'h0});
    endtask

    task automatic preload(input int w, input logic [31:0] v);
        pre_en = 1'b1; pre_addr = 13'(w); pre_data = v;
        ref_mem[w] = v;
        @(posedge hclk); #1;
        pre_en = 1'b0;
    endtask

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'd0;
    endtask

    // Pipelined master: runs seq, checks every data phase against the reference.
    // Entered and left at posedge+1.
    task automatic run_seq();
        int ai;
        int di;
        int dcyc;
        int guard;
        bit rdy;
        bit rd_done;
        ai = 0; di = -1; dcyc = 0; guard = 0;
        waits.delete();
        for (int k = 0; k < seq.size(); k++) waits.push_back(0);
        while ((ai < seq.size() || di >= 0) && guard < GUARD) begin
            if (ai < seq.size()) begin
                hsel = seq[ai].sel; htrans = seq[ai].trans; hwrite = seq[ai].wr;
                haddr = seq[ai].addr; hsize = seq[ai].size;
            end else begin
                drive_idle();
            end
            hwdata = (di >= 0 && seq[di].wr) ? seq[di].wdata : $urandom;
            @(negedge hclk);
            rdy = hreadyout;
            rd_done = 1'b0;
            if (di >= 0 && is_err(seq[di].size, seq[di].addr)) begin
                check(dcyc == 0 ? "err1_ready" : "err2_ready", 32'(hreadyout),
                      dcyc == 0 ? 32'd0 : 32'd1);
                check("err_resp", 32'(hresp), 32'd1);
            end else if (di >= 0) begin
                if (rdy) begin
                    check("okay_resp", 32'(hresp), 32'd0);
                    if (seq[di].wr) begin
                        ref_write(seq[di].addr, seq[di].size, seq[di].wdata);
                    end else begin
                        check("rdata", hrdata, ref_mem[int'(seq[di].addr[5:2])]);
                        last_rdata = hrdata;
                        rd_done = 1'b1;
                    end
                end else begin
                    waits[di]++;
                    stall_cyc = cyc;
                end
            end
            if (!rd_done) check("rdata_zero", hrdata, 32'h0);
            @(posedge hclk); #1;
            if (rdy) begin
                if (ai < seq.size()) begin
                    di = (seq[ai].sel && seq[ai].trans[1]) ? ai : -1;
                    ai++;
                end else begin
                    di = -1;
                end
                dcyc = 0;
            end else begin
                dcyc++;
            end
            guard++;
        end
        check("seq_timeout", 32'(guard < GUARD), 32'd1);
        drive_idle();
        seq.delete();
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int          r;
        int          nwr;

        hreset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        hwdata = 32'h0; last_rdata = 32'h0;
        drive_idle();
        @(posedge hclk); #1;

        // Reset and idle.
        for (int k = 0; k < 16; k++) preload(k, $urandom);
        @(negedge hclk);
        check("rst_ready", 32'(hreadyout), 32'd1);
        check("rst_resp", 32'(hresp), 32'd0);
        check("rst_cs", 32'(sram_cs), 32'd0);
        check("rst_rdata", hrdata, 32'h0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        check("idle_ready", 32'(hreadyout), 32'd1);
        check("idle_resp", 32'(hresp), 32'd0);
        check("idle_cs", 32'(sram_cs), 32'd0);
        check("idle_rdata", hrdata, 32'h0);
        @(posedge hclk); #1;

        // Write then back-to-back read of the same word.
        log_base = logq.size();
        add_xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        add_xfer(1'b0, 32'h10, 3'd2, 32'h0);
        add_idle(); add_idle();
        run_seq();
        check("wr_wait", 32'(waits[0]), 32'd0);
        check("rd_wait", 32'(waits[1]), 32'd0);
        check("merge_word", last_rdata, 32'hDEADBEEF);
        check("wr_log_n", 32'(logq.size() - log_base), 32'd2);
        check("wr_log_wen", 32'(logq[log_base+1].wen), 32'hF);
        check("wr_log_addr", 32'(logq[log_base+1].addr), 32'd4);
        check("wr_log_data", logq[log_base+1].data, 32'hDEADBEEF);

        // Partial merge.
        preload(4, 32'h11223344);
        add_xfer(1'b1, 32'h11, 3'd0, 32'h0000AA00);
        add_xfer(1'b0, 32'h10, 3'd2, 32'h0);
        add_idle(); add_idle();
        run_seq();
        check("merge_byte", last_rdata, 32'h1122AA44);

        // Stall rule: W0, W1, R back to back.
        log_base = logq.size();
        add_xfer(1'b1, 32'h0, 3'd2, 32'hA5A50001);
        add_xfer(1'b1, 32'h4, 3'd2, 32'h5A5A0002);
        add_xfer(1'b0, 32'h8, 3'd2, 32'h0);
        add_idle(); add_idle();
        run_seq();
        check("stall_w0", 32'(waits[0]), 32'd0);
        check("stall_w1", 32'(waits[1]), 32'd1);
        check("stall_rd", 32'(waits[2]), 32'd0);
        check("stall_drain_cyc", 32'(logq[log_base].cyc), 32'(stall_cyc));
        check("stall_drain_addr", 32'(logq[log_base].addr), 32'd0);
        check("stall_drain_wen", 32'(logq[log_base].wen), 32'hF);
        check("stall_drain_data", logq[log_base].data, 32'hA5A50001);
        check("stall_w1_data", logq[log_base+2].data, 32'h5A5A0002);
        check("stall_w1_addr", 32'(logq[log_base+2].addr), 32'd1);

        // Error response, then a valid read accepted in ERR2.
        log_base = logq.size();
        add_xfer(1'b0, 32'h02, 3'd2, 32'h0);
        add_xfer(1'b0, 32'h14, 3'd2, 32'h0);
        add_idle(); add_idle();
        run_seq();
        check("err_next_wait", 32'(waits[1]), 32'd0);
        check("err_log_n", 32'(logq.size() - log_base), 32'd1);
        check("err_log_addr", 32'(logq[log_base].addr), 32'd5);

        // Error accepted in ERR2, then a write.
        add_xfer(1'b0, 32'h06, 3'd1, 32'h0);
        add_xfer(1'b1, 32'h00, 3'd3, 32'h0);
        add_xfer(1'b1, 32'h18, 3'd2, 32'hC0FFEE11);
        add_idle(); add_idle();
        run_seq();

        // Reset during ERR1.
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h1; hsize = 3'd2;
        @(posedge hclk); #1;
        drive_idle(); hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        check("rst_err_ready", 32'(hreadyout), 32'd1);
        check("rst_err_resp", 32'(hresp), 32'd0);
        @(posedge hclk); #1;

        // Reset with a buffered, undrained write.
        old_val = ref_mem[7];
        log_base = logq.size();
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h1C; hsize = 3'd2;
        @(posedge hclk); #1;
        drive_idle(); hwdata = 32'hCAFEF00D;
        @(posedge hclk); #1;
        hreset = 1'b1;
        @(negedge hclk);
        check("rst_no_drain", 32'(sram_cs), 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        add_xfer(1'b0, 32'h1C, 3'd2, 32'h0);
        add_idle(); add_idle();
        run_seq();
        check("rst_old_data", last_rdata, old_val);
        nwr = 0;
        for (int k = log_base; k < logq.size(); k++) if (logq[k].wen != 4'b0000) nwr++;
        check("rst_no_write", 32'(nwr), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            a = $urandom;
            a[14:6] = '0;
            if (r < 15) begin
                if ($urandom_range(0, 1) == 0)
                    seq.push_back('{sel: 1'b0, trans: 2'($urandom), wr: 1'($urandom),
                                    addr: a, size: 3'd2, wdata: 32'h0});
                else
                    seq.push_back('{sel: 1'b1, trans: 2'($urandom_range(0, 1)), wr: 1'($urandom),
                                    addr: a, size: 3'd2, wdata: 32'h0});
            end else begin
                sz = ($urandom_range(0, 99) < 8) ? 3'($urandom_range(3, 7))
                                                 : 3'($urandom_range(0, 2));
                if ($urandom_range(0, 99) < 85) begin
                    if (sz == 3'd1) a[0] = 1'b0;
                    if (sz == 3'd2) a[1:0] = 2'b00;
                end
                seq.push_back('{sel: 1'b1, trans: ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11,
                                wr: (r < 57), addr: a, size: sz, wdata: $urandom});
            end
        end
        add_idle(); add_idle(); add_idle();
        run_seq();

        for (int k = 0; k < 16; k++) check($sformatf("mem_%0d", k), sram[k], ref_mem[k]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahblite_sram_slave.md
Name: ahblite_sram_slave

Overview:
AHB-Lite responder for on-chip single-port synchronous SRAM (ITCM/DTCM regions), sitting behind a bus-matrix output stage. It turns AHB-Lite transfers into SRAM cycles and gives zero-wait reads and writes through a one-entry posted write buffer with read-merge. Misaligned or oversized transfers get the two-cycle AHB ERROR response.

Parameters:
ADDR_WIDTH, 13, SRAM word-address width (2^ADDR_WIDTH x 32-bit words; default 32 KB)

Ports:
HCLK  input  1  clock
HRESET  input  1  synchronous reset, active-high
HSEL  input  1  slave select from decoder
HADDR  input  32  address; bits [ADDR_WIDTH+1:2] used as word index
HTRANS  input  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ
HSIZE  input  3  transfer size
HWRITE  input  1  1=write
HWDATA  input  32  write data (data phase)
HREADY  input  1  global ready from matrix
HREADYOUT  output  1  slave ready
HRESP  output  2  00 OKAY, 01 ERROR
HRDATA  output  32  read data
SRAM_CS  output  1  SRAM chip select
SRAM_WEN  output  4  per-byte write enable; 0000 = read
SRAM_ADDR  output  ADDR_WIDTH  SRAM word address
SRAM_WDATA  output  32  SRAM write data
SRAM_RDATA  input  32  SRAM read data, valid the cycle after a CS read

Behaviour:
- Accept = HSEL & HREADY & HTRANS[1]. All other cycles (IDLE, BUSY, unselected) get an OKAY, zero-wait response.
- Byte mask from HSIZE/HADDR[1:0]: byte -> 1<<HADDR[1:0]; half -> 0011 (HADDR[1]=0) or 1100; word -> 1111.
- Error transfer: HSIZE>2, half with HADDR[0]=1, or word with HADDR[1:0]!=0. It causes no SRAM access and no buffer load.
- Error FSM states are IDLE, ERR1, ERR2.
  - Accepted error transfer -> ERR1: HREADYOUT=0, HRESP=01.
  - ERR1 -> ERR2: HREADYOUT=1, HRESP=01.
  - ERR2 -> IDLE, or back to ERR1 if another error transfer is accepted in ERR2.
  - HTRANS changes during ERR1 are ignored because HREADY is low.
- Data-phase registers: dp_valid, dp_write, dp_addr, dp_mask. They load on every HREADY=1 edge; dp_valid=accept & ~error.
- Write buffer holds wb_valid, wb_addr, wb_data, wb_mask.
  - Loads {dp_addr, HWDATA, dp_mask} at the edge ending a write data phase with HREADYOUT=1.
- SRAM port priority each cycle:
  1. Accepted valid read in address phase: CS=1, WEN=0000, ADDR=HADDR word index (combinational).
  2. Otherwise, if wb_valid: drain with CS=1, WEN=wb_mask, ADDR=wb_addr, WDATA=wb_data. wb_valid clears at the edge unless reloaded in the same cycle.
  3. Otherwise CS=0, WEN=0000.
- Write stall: if a write data phase is active, wb_valid=1, and HSEL & HTRANS[1] & ~HWRITE is true this cycle, then HREADYOUT=0 for one cycle.
  - The stall condition uses raw HSEL/HTRANS, not HREADY, so there is no combinational loop.
  - Because the read is not accepted, the buffer drains; the next cycle completes the write with HREADYOUT=1.
- Read data phase: HRDATA byte i = wb_data byte i if wb_valid & wb_addr==dp_addr & wb_mask[i], else SRAM_RDATA byte i. Read latency is zero wait states.
- HRDATA=0 outside a read data phase. HRESP=00 except in ERR1/ERR2.
- Reset (synchronous, HRESET=1):
  - dp_valid=0, wb_valid=0, FSM=IDLE, HREADYOUT=1, HRESP=00, SRAM_CS=0, HRDATA=0.
  - A buffered but undrained write is discarded.
  - Reset during ERR1 returns HREADYOUT=1 the next cycle.
- Upper address bits above ADDR_WIDTH+1 are ignored; region decode belongs to the matrix.

Test Plan:
- Reset and idle: hold HRESET 2 cycles with HSEL=0 -> HREADYOUT=1, HRESP=00, SRAM_CS=0, HRDATA=0.
- Write then read: word write 0xDEADBEEF @0x10, then read @0x10 back-to-back -> read is zero-wait, HRDATA=0xDEADBEEF served from buffer merge; SRAM is written afterwards with WEN=1111, ADDR=4.
- Partial merge: SRAM word 4 = 0x11223344; byte write 0xAA @0x11; read word @0x10 -> HRDATA=0x1122AA44.
- Stall rule: W0 @0x0, W1 @0x4, then R @0x8 on consecutive cycles -> exactly one HREADYOUT=0 cycle in the W1 data phase, W0 drained in that cycle, all data correct.
- Error: word read @0x02 -> no SRAM_CS; ERR1 gives HREADYOUT=0/HRESP=01; ERR2 gives HREADYOUT=1/HRESP=01. A valid transfer accepted in ERR2 completes OKAY.
- Reset mid-operation: write data phase, then HRESET=1 before drain -> wb_valid=0; a later read of that address returns the old SRAM contents.
